cpu_seq_ctrl: RTL
=================

Name: cpu_seq_ctrl

Overview:
Multi-cycle sequencer for the RV32I datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It gates the PC, instruction-register, register-file and data-memory write/read strobes, and takes its per-instruction intent from main_ctrl and branch_ctrl. It sits between those decoders and the datapath enables. It also handles variable-latency dmem via an ack handshake with a timeout trap.

Parameters:
TIMEOUT, 15, maximum MEM cycles without mem_ack before TRAP; 0 disables the timeout
STATE_W, 3, state encoding width (fixed; not overridable in practice)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
run  in  1  level; 1 = keep executing, 0 = stop at next instruction boundary
opcode  in  7  inst[6:0] from the instruction register
reg_wr_d  in  1  main_ctrl reg_wr intent
mem_rd_d  in  1  main_ctrl mem_rd intent
mem_wr_d  in  1  main_ctrl mem_wr intent
br_en_d  in  1  branch_ctrl br_en (branch/jump taken)
mem_ack  in  1  dmem access complete this cycle
ir_wr  out  1  latch imem output into IR
pc_wr  out  1  update PC
br_take  out  1  PC mux select (1 = alu_o, 0 = pc+4)
reg_wr  out  1  register-file write enable
mem_rd  out  1  dmem read request
mem_wr  out  1  dmem write request
state  out  3  current state code
busy  out  1  1 in FETCH..WB
halted  out  1  1 in HALT or TRAP
trap  out  1  1 in TRAP
instret  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- State codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, TRAP=7. One state register plus a timeout counter of width $clog2(TIMEOUT+1) (min 1).
- Reset (rst=0, async): state=IDLE, counter=0, instret=0. All outputs 0 immediately, including mid-MEM; an in-flight access is abandoned.
- Outputs are a Moore decode of state. The only exceptions are reg_wr and br_take in WB, which also depend on inputs.
- IDLE: all strobes 0. run=1 -> FETCH.
- FETCH: ir_wr=1 for exactly one cycle -> DECODE.
- DECODE: the legal opcode set is 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011.
  - opcode=1110011 (SYSTEM) -> HALT.
  - Any other illegal opcode -> TRAP.
  - Otherwise -> EXEC.
- EXEC: no strobes. If mem_rd_d|mem_wr_d -> MEM (counter cleared to 0); else -> WB.
- MEM: mem_rd=mem_rd_d and mem_wr=mem_wr_d, held every MEM cycle.
  - mem_ack=1 -> WB.
  - mem_ack=0 with counter==TIMEOUT and TIMEOUT!=0 -> TRAP.
  - Otherwise counter+1, stay.
  - mem_ack and timeout in the same cycle: ack wins.
  - MEM therefore lasts at most TIMEOUT+1 cycles.
- WB: one cycle. pc_wr=1, reg_wr=reg_wr_d, br_take=br_en_d. Then run=1 -> FETCH, run=0 -> IDLE.
- Instruction latency: 4 cycles without memory; 4+N with N MEM cycles.
- run deasserted mid-instruction: the instruction completes through WB, then the block enters IDLE. run is sampled only in IDLE and WB.
- mem_ack outside MEM is ignored.
- HALT and TRAP are absorbing: all strobes 0, run ignored, exit only by reset.

Optional Feature:
Macro INSTRET_EN.
- Defined: instret increments by 1 in every WB cycle, wrapping 0xFFFFFFFF -> 0. It is cleared by reset and holds its value in HALT and TRAP.
- Undefined: instret is tied to 0 and no counter flops are synthesized.

Test Plan:
1. Release rst, run=1, opcode=0110011, reg_wr_d=1 -> state sequence 1,2,3,5,1. ir_wr high in FETCH only; reg_wr=pc_wr=1 in WB only; 4 cycles per instruction.
2. opcode=0000011, mem_rd_d=1, mem_ack on 3rd MEM cycle -> mem_rd high exactly 3 cycles, then WB with reg_wr=1; 7 cycles total. With INSTRET_EN, instret 0->1.
3. opcode=0100011, mem_wr_d=1, mem_ack never -> mem_wr high 16 cycles, then state=7, trap=1, halted=1. Repeat with ack on the 16th MEM cycle -> WB, no trap.
4. opcode=1100011 with br_en_d=1 -> br_take=1 and pc_wr=1 in WB. With br_en_d=0 -> br_take=0, pc_wr=1.
5. opcode=1110011 -> state=6, halted=1, trap=0, stays there with run=1. opcode=0000000 -> state=7, trap=1.
6. run->0 during EXEC -> WB completes, then IDLE with busy=0. Separately, rst->0 mid-MEM -> all outputs 0 before the next clk edge; after release, state=0.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I datapath, with a dmem ack timeout trap.
// Define INSTRET_EN to build the retired-instruction counter; otherwise instret is tied to zero.
`timescale 1ns/1ps

module cpu_seq_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int STATE_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [6:0]         opcode,
    input  logic               reg_wr_d,
    input  logic               mem_rd_d,
    input  logic               mem_wr_d,
    input  logic               br_en_d,
    input  logic               mem_ack,
    output logic               ir_wr,
    output logic               pc_wr,
    output logic               br_take,
    output logic               reg_wr,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [STATE_W-1:0] state,
    output logic               busy,
    output logic               halted,
    output logic               trap,
    output logic [31:0]        instret
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             opc_legal;
    logic             timeout_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // SYSTEM is in the legal set; DECODE separates it out as the halt request.
    always_comb begin
        case (opcode)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011:
                opc_legal = 1'b1;
            default:
                opc_legal = 1'b0;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TIMEOUT_C);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ir_wr   = 1'b0;
        pc_wr   = 1'b0;
        br_take = 1'b0;
        reg_wr  = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_wr   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == 7'b1110011) state_d = S_HALT;
                else if (!opc_legal)      state_d = S_TRAP;
                else                      state_d = S_EXEC;
            end
            S_EXEC: begin
                if (mem_rd_d || mem_wr_d) begin
                    state_d = S_MEM;
                    cnt_d   = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            // An ack arriving on the final allowed cycle still completes the access.
            S_MEM: begin
                mem_rd = mem_rd_d;
                mem_wr = mem_wr_d;
                if (mem_ack)          state_d = S_WB;
                else if (timeout_hit) state_d = S_TRAP;
                else                  cnt_d   = cnt_q + CNT_W'(1);
            end
            S_WB: begin
                pc_wr   = 1'b1;
                reg_wr  = reg_wr_d;
                br_take = br_en_d;
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT, S_TRAP: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state  = state_q;
    assign busy   = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC) ||
                    (state_q == S_MEM)   || (state_q == S_WB);
    assign halted = (state_q == S_HALT) || (state_q == S_TRAP);
    assign trap   = (state_q == S_TRAP);

`ifdef INSTRET_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 instret_q <= '0;
        else if (state_q == S_WB) instret_q <= instret_q + 32'd1;
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule
